// File: rtl/train_disp_pkg.sv
// Shared types and constants for the 4-digit BCD display path.
// Used by bcd_display_driver and bin2bcd_iter.
package train_disp_pkg;

    localparam int unsigned DIGITS_DEF      = 4;
    localparam int unsigned REFRESH_DIV_DEF = 50000;
    localparam int unsigned AN_MAX_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } disp_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Active-low one-hot anode pattern; callers truncate it to their digit count.
    function automatic logic [AN_MAX_W-1:0] an_onehot_n(input int unsigned idx);
        return ~(AN_MAX_W'(1) << idx);
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// IDLE -> CONV (BIN_W cycles) -> COMMIT (done pulse) -> IDLE.
module bin2bcd_iter
    import train_disp_pkg::*;
#(
    parameter int unsigned BIN_W  = 14,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_vec
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ACC_W = DIGITS * 4;

    disp_state_t      state_q, state_d;
    logic [BIN_W-1:0] sr_q, sr_d;
    logic [ACC_W-1:0] acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                {acc_d, sr_d} = {acc_adj, sr_q} << 1;
                cnt_d         = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign bcd_vec = acc_q;

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD display driver: converts a value and time-multiplexes the digits onto one bus.
// Optional LEADING_ZERO_BLANK_EN darkens leading-zero slots (LSD always lit).
module bcd_display_driver
    import train_disp_pkg::*;
#(
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned DIGITS      = DIGITS_DEF,
    parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  value_in,
    input  logic              load,
    output logic              ready,
    output logic              ovf,
    output logic [3:0]        bcd,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned     IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned     RCNT_W  = $clog2(REFRESH_DIV);
    localparam longint unsigned MAX_VAL = 64'd10 ** DIGITS;

    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic [DIGITS*4-1:0] conv_bcd;
    logic                value_ovf;

    logic                ovf_pend_q;
    logic                ovf_q;
    bcd_digit_t          digit_q [DIGITS];

    logic [RCNT_W-1:0]   rcnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DIGITS-1:0]   an_q, an_d;
    bcd_digit_t          bcd_q, bcd_d;
    logic                blank;

    assign ready      = ~conv_busy;
    assign conv_start = load & ready;
    assign value_ovf  = (64'(value_in) >= MAX_VAL);

    bin2bcd_iter #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin     (value_in),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_vec (conv_bcd)
    );

    // Overflow is judged on the accepted value but only published at commit time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            if (conv_start) begin
                ovf_pend_q <= value_ovf;
            end
            if (conv_done) begin
                ovf_q <= ovf_pend_q;
                for (int i = 0; i < int'(DIGITS); i++) begin
                    digit_q[i] <= ovf_pend_q ? 4'd9 : conv_bcd[i*4 +: 4];
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] lead_zero;
    logic              zero_above;

    always_comb begin
        lead_zero  = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above   = zero_above & (digit_q[i] == 4'd0);
            lead_zero[i] = zero_above;
        end
        lead_zero[0] = 1'b0;
    end

    assign blank = lead_zero[idx_q];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_d  = blank ? '1 : DIGITS'(an_onehot_n(32'(idx_q)));
        bcd_d = digit_q[idx_q];
    end

    // Scan free-runs in every converter state; outputs follow idx_q one edge later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rcnt_q <= '0;
            idx_q  <= IDX_W'(DIGITS - 1);
            an_q   <= '1;
            bcd_q  <= '0;
        end else begin
            if (rcnt_q == RCNT_W'(REFRESH_DIV - 1)) begin
                rcnt_q <= '0;
                idx_q  <= (idx_q == '0) ? IDX_W'(DIGITS - 1) : idx_q - 1'b1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            an_q  <= an_d;
            bcd_q <= bcd_d;
        end
    end

    assign an  = an_q;
    assign bcd = bcd_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_display_driver.sv
// Directed self-checking bench for bcd_display_driver with REFRESH_DIV=4.
`timescale 1ns/1ps
module tb_bcd_display_driver;

    localparam int unsigned BIN_W       = 14;
    localparam int unsigned DIGITS      = 4;
    localparam int unsigned REFRESH_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ_SMALL = 4'b1110;
    localparam logic [3:0] AN_FIRST = 4'b1111;
`else
    localparam logic [3:0] LZ_SMALL = 4'b0000;
    localparam logic [3:0] AN_FIRST = 4'b0111;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [BIN_W-1:0] value_in = '0;
    logic             load = 1'b0;
    logic             ready;
    logic             ovf;
    logic [3:0]       bcd;
    logic [3:0]       an;

    int n_cmp = 0;
    int n_err = 0;

    bcd_display_driver #(
        .BIN_W       (BIN_W),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .load     (load),
        .ready    (ready),
        .ovf      (ovf),
        .bcd      (bcd),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int guard;
        guard = 0;
        while (ready !== 1'b1 && guard < 40) begin
            tick();
            guard++;
        end
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: ready=%b, required 1 within 40 cycles", name, ready);
        end
    endtask

    task automatic do_load(input logic [BIN_W-1:0] v, input string name);
        wait_ready({name, "_pre"});
        value_in = v;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        wait_ready({name, "_done"});
    endtask

    // Syncs to the first cycle of the rightmost slot, then checks one full 16-cycle frame.
    task automatic check_scan(input logic [15:0] dig, input logic [3:0] blank_mask,
                              input string name);
        logic [3:0] prev;
        logic [3:0] exp_an;
        logic [3:0] exp_bcd;
        int         s;
        bit         found;
        found = 1'b0;
        prev  = an;
        for (int g = 0; g < 40 && !found; g++) begin
            tick();
            if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
            else prev = an;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL %s_sync: an=%b, required a fresh 1110 within 40 cycles", name, an);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k > 0) tick();
                s       = (k < 4) ? 0 : 4 - (k / 4);
                exp_an  = blank_mask[s] ? 4'b1111 : ~(4'b0001 << s);
                exp_bcd = dig[s*4 +: 4];
                n_cmp++;
                if (an !== exp_an || bcd !== exp_bcd) begin
                    n_err++;
                    $display("FAIL %s_scan k=%0d: an=%b bcd=%0d, required an=%b bcd=%0d",
                             name, k, an, bcd, exp_an, exp_bcd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (an !== 4'b1111 || ready !== 1'b1 || bcd !== 4'd0 || ovf !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold: an=%b ready=%b bcd=%0d ovf=%b, required 1111 1 0 0",
                         an, ready, bcd, ovf);
            end
        end
        rst_n = 1'b1;
        n_cmp++;
        if (an !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_release: an=%b, required 1111", an);
        end
        tick();
        n_cmp++;
        if (an !== AN_FIRST || bcd !== 4'd0) begin
            n_err++;
            $display("FAIL reset_first_edge: an=%b bcd=%0d, required an=%b bcd=0",
                     an, bcd, AN_FIRST);
        end
    endtask

    task automatic test_load_latency();
        logic [3:0] exp_bcd;
        wait_ready("lat_pre");
        value_in = 14'd1234;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL lat_ready_drop: ready=%b, required 0", ready);
        end
        for (int e = 1; e <= 14; e++) begin
            tick();
            n_cmp++;
            if (ready !== 1'b0 || bcd !== 4'd0) begin
                n_err++;
                $display("FAIL lat_busy e=%0d: ready=%b bcd=%0d, required ready=0 bcd=0",
                         e, ready, bcd);
            end
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || bcd !== 4'd0) begin
            n_err++;
            $display("FAIL lat_commit: ready=%b bcd=%0d, required ready=1 bcd=0", ready, bcd);
        end
        tick();
        case (an)
            4'b0111: exp_bcd = 4'd1;
            4'b1011: exp_bcd = 4'd2;
            4'b1101: exp_bcd = 4'd3;
            4'b1110: exp_bcd = 4'd4;
            default: exp_bcd = 4'hf;
        endcase
        n_cmp++;
        if (bcd !== exp_bcd) begin
            n_err++;
            $display("FAIL lat_visible: an=%b bcd=%0d, required bcd=%0d", an, bcd, exp_bcd);
        end
        check_scan(16'h1234, 4'b0000, "v1234");
    endtask

    task automatic test_overflow();
        do_load(14'd12000, "ovf12000");
        n_cmp++;
        if (ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set: ovf=%b, required 1", ovf);
        end
        check_scan(16'h9999, 4'b0000, "v12000");
        do_load(14'd7, "v7");
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clear: ovf=%b, required 0", ovf);
        end
        check_scan(16'h0007, LZ_SMALL, "v7");
    endtask

    task automatic test_back_to_back();
        wait_ready("b2b_pre");
        value_in = 14'd4321;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        value_in = 14'd9999;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        value_in = '0;
        for (int e = 7; e <= 14; e++) tick();
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_busy_e14: ready=%b, required 0", ready);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_ready_e15: ready=%b, required 1", ready);
        end
        tick();
        n_cmp++;
        if (ready !== 1'b1 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_no_queue: ready=%b ovf=%b, required 1 0", ready, ovf);
        end
        check_scan(16'h4321, 4'b0000, "v4321");
    endtask

    task automatic test_reset_abort();
        wait_ready("abort_pre");
        value_in = 14'd5678;
        load     = 1'b1;
        tick();
        load     = 1'b0;
        for (int e = 1; e <= 8; e++) tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (ready !== 1'b1 || an !== 4'b1111 || bcd !== 4'd0 || ovf !== 1'b0) begin
            n_err++;
            $display("FAIL abort_reset: ready=%b an=%b bcd=%0d ovf=%b, required 1 1111 0 0",
                     ready, an, bcd, ovf);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (an !== AN_FIRST || bcd !== 4'd0) begin
            n_err++;
            $display("FAIL abort_idx: an=%b bcd=%0d, required an=%b bcd=0", an, bcd, AN_FIRST);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            n_cmp++;
            if (bcd !== 4'd0 || ready !== 1'b1) begin
                n_err++;
                $display("FAIL abort_quiet c=%0d: bcd=%0d ready=%b, required 0 1", c, bcd, ready);
            end
        end
        check_scan(16'h0000, LZ_SMALL, "abort");
    endtask

    task automatic test_zero();
        do_load(14'd0, "v0");
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL zero_ovf: ovf=%b, required 0", ovf);
        end
        check_scan(16'h0000, LZ_SMALL, "v0");
    endtask

    initial begin
        test_reset();
        test_load_latency();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_zero();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
